// File: rtl/control_teclado.sv
// PS/2 scan-code sequencer: folds E0/F0 prefixes into 10-bit key events and queues them in a FWFT FIFO.
// Latency: an event is visible at evento/hay_evento one cycle after the rx_tick of its final byte.
// Backpressure: none toward the receiver; a push into a full FIFO (without a pop) is dropped and flagged in desborde.
module control_teclado #(
  parameter int PROF     = 4,
  parameter int T_ESPERA = 100000
) (
  input  logic       reloj,
  input  logic       reset,
  input  logic       rx_tick,
  input  logic [7:0] rx_dato,
  input  logic       rx_paridad_ok,
  input  logic       leer,
  output logic [9:0] evento,
  output logic       hay_evento,
  output logic       lleno,
  output logic       err_paridad,
  output logic [7:0] cuenta_err,
  output logic       desborde
);

  localparam int AW = $clog2(PROF);
  localparam int OW = AW + 1;
  localparam int CW = $clog2(T_ESPERA + 1);

  localparam logic [7:0] COD_EXT = 8'hE0;
  localparam logic [7:0] COD_SOL = 8'hF0;

  typedef enum logic [1:0] {
    REPOSO,
    PRE_EXT,
    PRE_SOL,
    PRE_EXT_SOL
  } estado_t;

  estado_t       estado, estado_sig;
  logic [CW-1:0] cnt_espera;
  logic          push;
  logic [9:0]    ev_nuevo;
  logic          err_det;

  logic [9:0]    mem [PROF];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [OW-1:0] ocup;
  logic          pop;
  logic          escribe;

  // Sequencer state register.
  always_ff @(posedge reloj) begin
    if (!reset) estado <= REPOSO;
    else        estado <= estado_sig;
  end

  // Next-state decode: prefix tracking, event build, parity rejection and prefix timeout.
  always_comb begin
    estado_sig = estado;
    push       = 1'b0;
    ev_nuevo   = '0;
    err_det    = 1'b0;
    if (rx_tick) begin
      if (!rx_paridad_ok) begin
        err_det    = 1'b1;
        estado_sig = REPOSO;
      end else begin
        case (estado)
          REPOSO: begin
            if (rx_dato == COD_EXT)      estado_sig = PRE_EXT;
            else if (rx_dato == COD_SOL) estado_sig = PRE_SOL;
            else begin
              push     = 1'b1;
              ev_nuevo = {2'b00, rx_dato};
            end
          end
          PRE_EXT: begin
            if (rx_dato == COD_SOL)      estado_sig = PRE_EXT_SOL;
            else if (rx_dato == COD_EXT) estado_sig = PRE_EXT;
            else begin
              push       = 1'b1;
              ev_nuevo   = {2'b01, rx_dato};
              estado_sig = REPOSO;
            end
          end
          PRE_SOL: begin
            // A second prefix after a break prefix is malformed: drop the whole sequence.
            estado_sig = REPOSO;
            if (rx_dato != COD_EXT && rx_dato != COD_SOL) begin
              push     = 1'b1;
              ev_nuevo = {2'b10, rx_dato};
            end
          end
          PRE_EXT_SOL: begin
            estado_sig = REPOSO;
            if (rx_dato != COD_EXT && rx_dato != COD_SOL) begin
              push     = 1'b1;
              ev_nuevo = {2'b11, rx_dato};
            end
          end
          default: estado_sig = REPOSO;
        endcase
      end
    end else if (estado != REPOSO && cnt_espera == CW'(T_ESPERA - 1)) begin
      // This idle cycle is the T_ESPERA-th since the last byte: abandon the prefix.
      estado_sig = REPOSO;
    end
  end

  // Prefix timeout counter: runs only while a prefix is pending and no byte arrives.
  always_ff @(posedge reloj) begin
    if (!reset || estado == REPOSO || rx_tick) cnt_espera <= '0;
    else                                       cnt_espera <= cnt_espera + 1'b1;
  end

  // Parity error pulse and saturating error count.
  always_ff @(posedge reloj) begin
    if (!reset) begin
      err_paridad <= 1'b0;
      cuenta_err  <= '0;
    end else begin
      err_paridad <= err_det;
      if (err_det && cuenta_err != 8'hFF) cuenta_err <= cuenta_err + 1'b1;
    end
  end

  // A pop needs a non-empty FIFO; a push into a full FIFO only lands if the head leaves the same cycle.
  assign pop     = leer && hay_evento;
  assign escribe = push && (!lleno || pop);

  // Event storage; no reset needed since occupancy gates what is visible.
  always_ff @(posedge reloj) begin
    if (reset && escribe) mem[wr_ptr] <= ev_nuevo;
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge reloj) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ocup     <= '0;
      desborde <= 1'b0;
    end else begin
      if (escribe) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({escribe, pop})
        2'b10:   ocup <= ocup + 1'b1;
        2'b01:   ocup <= ocup - 1'b1;
        default: ocup <= ocup;
      endcase
      if (push && !escribe) desborde <= 1'b1;
    end
  end

  assign hay_evento = (ocup != '0);
  assign lleno      = (ocup == OW'(PROF));
  assign evento     = hay_evento ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_control_teclado.sv
// Directed bench for control_teclado: prefix folding, parity errors, timeout, reset and FIFO limits.
// Inputs change on the falling edge and outputs are sampled on the falling edge after each rising edge.
// Each task consumes whole cycles and leaves the bench at a falling edge.
module tb_control_teclado;

  localparam int PROF     = 4;
  localparam int T_ESPERA = 20;

  logic       reloj = 1'b0;
  logic       reset;
  logic       rx_tick;
  logic [7:0] rx_dato;
  logic       rx_paridad_ok;
  logic       leer;
  logic [9:0] evento;
  logic       hay_evento;
  logic       lleno;
  logic       err_paridad;
  logic [7:0] cuenta_err;
  logic       desborde;

  int errors = 0;
  int checks = 0;

  control_teclado #(.PROF(PROF), .T_ESPERA(T_ESPERA)) dut (
    .reloj(reloj), .reset(reset), .rx_tick(rx_tick), .rx_dato(rx_dato),
    .rx_paridad_ok(rx_paridad_ok), .leer(leer), .evento(evento),
    .hay_evento(hay_evento), .lleno(lleno), .err_paridad(err_paridad),
    .cuenta_err(cuenta_err), .desborde(desborde)
  );

  always #5 reloj = ~reloj;

  task automatic send(input logic [7:0] b, input logic ok);
    rx_tick = 1'b1; rx_dato = b; rx_paridad_ok = ok;
    @(negedge reloj);
    rx_tick = 1'b0; rx_dato = 8'h00; rx_paridad_ok = 1'b0;
  endtask

  task automatic pop_one();
    leer = 1'b1;
    @(negedge reloj);
    leer = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge reloj);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(negedge reloj);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    // Traffic during reset must be ignored.
    reset = 1'b0; rx_tick = 1'b1; rx_dato = 8'h1C; rx_paridad_ok = 1'b1; leer = 1'b1;
    idle(3);
    checks++; if (evento !== 10'h000) begin errors++; $display("FAIL reset_evento: got %h expected 000", evento); end
    checks++; if (hay_evento !== 1'b0) begin errors++; $display("FAIL reset_hay: got %b expected 0", hay_evento); end
    checks++; if (lleno !== 1'b0) begin errors++; $display("FAIL reset_lleno: got %b expected 0", lleno); end
    checks++; if (err_paridad !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err_paridad); end
    checks++; if (cuenta_err !== 8'h00) begin errors++; $display("FAIL reset_cuenta: got %h expected 00", cuenta_err); end
    checks++; if (desborde !== 1'b0) begin errors++; $display("FAIL reset_desborde: got %b expected 0", desborde); end
    rx_tick = 1'b0; rx_dato = 8'h00; rx_paridad_ok = 1'b0; leer = 1'b0; reset = 1'b1;
    idle(1);
  endtask

  task automatic test_make();
    send(8'h1C, 1'b1);
    checks++; if (hay_evento !== 1'b1) begin errors++; $display("FAIL make_hay: got %b expected 1", hay_evento); end
    checks++; if (evento !== 10'h01C) begin errors++; $display("FAIL make_evento: got %h expected 01c", evento); end
    pop_one();
    checks++; if (hay_evento !== 1'b0) begin errors++; $display("FAIL make_pop: got %b expected 0", hay_evento); end
  endtask

  task automatic test_break();
    send(8'hF0, 1'b1);
    checks++; if (hay_evento !== 1'b0) begin errors++; $display("FAIL break_prefix: got %b expected 0", hay_evento); end
    send(8'h1C, 1'b1);
    checks++; if (evento !== 10'h21C) begin errors++; $display("FAIL break_evento: got %h expected 21c", evento); end
    pop_one();
    checks++; if (hay_evento !== 1'b0) begin errors++; $display("FAIL break_single: got %b expected 0", hay_evento); end
  endtask

  task automatic test_ext_break();
    send(8'hE0, 1'b1);
    send(8'hF0, 1'b1);
    checks++; if (hay_evento !== 1'b0) begin errors++; $display("FAIL extbrk_prefix: got %b expected 0", hay_evento); end
    send(8'h75, 1'b1);
    checks++; if (evento !== 10'h375) begin errors++; $display("FAIL extbrk_evento: got %h expected 375", evento); end
    pop_one();
    checks++; if (hay_evento !== 1'b0) begin errors++; $display("FAIL extbrk_single: got %b expected 0", hay_evento); end
    // Repeated E0 keeps the extended prefix.
    send(8'hE0, 1'b1); send(8'hE0, 1'b1); send(8'h74, 1'b1);
    checks++; if (evento !== 10'h174) begin errors++; $display("FAIL ext_repeat: got %h expected 174", evento); end
    pop_one();
  endtask

  task automatic test_parity();
    send(8'hE0, 1'b1);
    send(8'h75, 1'b0);
    checks++; if (err_paridad !== 1'b1) begin errors++; $display("FAIL par_pulse: got %b expected 1", err_paridad); end
    checks++; if (cuenta_err !== 8'h01) begin errors++; $display("FAIL par_cuenta: got %h expected 01", cuenta_err); end
    checks++; if (hay_evento !== 1'b0) begin errors++; $display("FAIL par_noevent: got %b expected 0", hay_evento); end
    idle(1);
    checks++; if (err_paridad !== 1'b0) begin errors++; $display("FAIL par_pulse_end: got %b expected 0", err_paridad); end
    send(8'h1C, 1'b1);
    checks++; if (evento !== 10'h01C) begin errors++; $display("FAIL par_after: got %h expected 01c", evento); end
    pop_one();
  endtask

  task automatic test_discard();
    // E0 after F0 drops the sequence without an error.
    send(8'hF0, 1'b1);
    send(8'hE0, 1'b1);
    checks++; if (hay_evento !== 1'b0) begin errors++; $display("FAIL discard_noevent: got %b expected 0", hay_evento); end
    send(8'h1C, 1'b1);
    checks++; if (evento !== 10'h01C) begin errors++; $display("FAIL discard_next: got %h expected 01c", evento); end
    checks++; if (cuenta_err !== 8'h01) begin errors++; $display("FAIL discard_cuenta: got %h expected 01", cuenta_err); end
    pop_one();
  endtask

  task automatic test_timeout();
    send(8'hE0, 1'b1);
    idle(T_ESPERA - 1);
    send(8'h75, 1'b1);
    checks++; if (evento !== 10'h175) begin errors++; $display("FAIL tout_before: got %h expected 175", evento); end
    pop_one();
    send(8'hE0, 1'b1);
    idle(T_ESPERA);
    checks++; if (hay_evento !== 1'b0) begin errors++; $display("FAIL tout_noevent: got %b expected 0", hay_evento); end
    send(8'h75, 1'b1);
    checks++; if (evento !== 10'h075) begin errors++; $display("FAIL tout_expired: got %h expected 075", evento); end
    pop_one();
  endtask

  task automatic test_reset_mid();
    send(8'h11, 1'b1);
    send(8'hF0, 1'b1);
    do_reset();
    checks++; if (hay_evento !== 1'b0) begin errors++; $display("FAIL rstmid_flush: got %b expected 0", hay_evento); end
    checks++; if (cuenta_err !== 8'h00) begin errors++; $display("FAIL rstmid_cuenta: got %h expected 00", cuenta_err); end
    send(8'h1C, 1'b1);
    checks++; if (evento !== 10'h01C) begin errors++; $display("FAIL rstmid_evento: got %h expected 01c", evento); end
    pop_one();
    checks++; if (hay_evento !== 1'b0) begin errors++; $display("FAIL rstmid_single: got %b expected 0", hay_evento); end
  endtask

  task automatic test_fifo_full();
    logic [9:0] exp;
    for (int i = 1; i <= 4; i++) send(8'(i), 1'b1);
    checks++; if (lleno !== 1'b1) begin errors++; $display("FAIL full_lleno: got %b expected 1", lleno); end
    checks++; if (desborde !== 1'b0) begin errors++; $display("FAIL full_nodrop: got %b expected 0", desborde); end
    send(8'h05, 1'b1);
    checks++; if (desborde !== 1'b1) begin errors++; $display("FAIL full_desborde: got %b expected 1", desborde); end
    for (int i = 1; i <= 4; i++) begin
      exp = 10'(i);
      checks++; if (evento !== exp) begin errors++; $display("FAIL full_order%0d: got %h expected %h", i, evento, exp); end
      pop_one();
      checks++; if (lleno !== 1'b0) begin errors++; $display("FAIL full_lleno_pop%0d: got %b expected 0", i, lleno); end
    end
    checks++; if (hay_evento !== 1'b0) begin errors++; $display("FAIL full_empty: got %b expected 0", hay_evento); end
    checks++; if (desborde !== 1'b1) begin errors++; $display("FAIL full_sticky: got %b expected 1", desborde); end
  endtask

  task automatic test_back_to_back();
    logic [9:0] exp;
    do_reset();
    for (int i = 0; i < 4; i++) send(8'h0A + 8'(i), 1'b1);
    // Push and pop together on a full FIFO.
    rx_tick = 1'b1; rx_dato = 8'h0E; rx_paridad_ok = 1'b1; leer = 1'b1;
    @(negedge reloj);
    rx_tick = 1'b0; rx_dato = 8'h00; rx_paridad_ok = 1'b0; leer = 1'b0;
    checks++; if (lleno !== 1'b1) begin errors++; $display("FAIL b2b_lleno: got %b expected 1", lleno); end
    checks++; if (desborde !== 1'b0) begin errors++; $display("FAIL b2b_nodrop: got %b expected 0", desborde); end
    for (int i = 0; i < 4; i++) begin
      exp = 10'h00B + 10'(i);
      checks++; if (evento !== exp) begin errors++; $display("FAIL b2b_order%0d: got %h expected %h", i, evento, exp); end
      pop_one();
    end
    checks++; if (hay_evento !== 1'b0) begin errors++; $display("FAIL b2b_empty: got %b expected 0", hay_evento); end
    // Pop on empty is ignored.
    pop_one();
    checks++; if (hay_evento !== 1'b0) begin errors++; $display("FAIL b2b_popempty: got %b expected 0", hay_evento); end
    // Push with pop on an empty FIFO: only the push happens.
    rx_tick = 1'b1; rx_dato = 8'h22; rx_paridad_ok = 1'b1; leer = 1'b1;
    @(negedge reloj);
    rx_tick = 1'b0; rx_dato = 8'h00; rx_paridad_ok = 1'b0; leer = 1'b0;
    checks++; if (hay_evento !== 1'b1) begin errors++; $display("FAIL b2b_emptypush: got %b expected 1", hay_evento); end
    checks++; if (evento !== 10'h022) begin errors++; $display("FAIL b2b_emptyval: got %h expected 022", evento); end
    pop_one();
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 254; i++) send(8'h55, 1'b0);
    checks++; if (cuenta_err !== 8'hFE) begin errors++; $display("FAIL sat_254: got %h expected fe", cuenta_err); end
    send(8'h55, 1'b0);
    checks++; if (cuenta_err !== 8'hFF) begin errors++; $display("FAIL sat_255: got %h expected ff", cuenta_err); end
    send(8'h55, 1'b0);
    checks++; if (cuenta_err !== 8'hFF) begin errors++; $display("FAIL sat_hold: got %h expected ff", cuenta_err); end
    checks++; if (err_paridad !== 1'b1) begin errors++; $display("FAIL sat_pulse: got %b expected 1", err_paridad); end
  endtask

  initial begin
    reset = 1'b0; rx_tick = 1'b0; rx_dato = 8'h00; rx_paridad_ok = 1'b0; leer = 1'b0;
    @(negedge reloj);
    test_reset();
    test_make();
    test_break();
    test_ext_break();
    test_parity();
    test_discard();
    test_timeout();
    test_reset_mid();
    test_fifo_full();
    test_back_to_back();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
